// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/add ops plus iterative MUL/MULHU/DIVU/REMU.
// Latency: single-cycle ops report done the cycle after start; iterative ops take WIDTH edges.
// Backpressure: start is ignored while busy; the control unit stalls the PC on busy.
module alu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;      // sel[1:0] of the iterative op: bit1=divide, bit0=high half/remainder
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;      // product upper half, or partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;      // product lower half/multiplier, or dividend/quotient
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;
  logic [WIDTH-1:0] iter_res;

  // Single-cycle datapath: shared adder for ADD/SUB/SLT, SLT uses sign XOR overflow
  always_comb begin
    is_sub  = (sel == 4'b0110) || (sel == 4'b0111);
    b_eff   = is_sub ? ~b : b;
    sum     = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
    add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    alu_res = '0;
    case (sel)
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b0010: alu_res = sum;
      4'b0110: alu_res = sum;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      4'b0100: alu_res = a & ~b;
      4'b0101: alu_res = a | ~b;
      default: alu_res = '0;
    endcase
    alu_ovf = ((sel == 4'b0010) || (sel == 4'b0110)) && add_ovf;
  end

  // One iteration step: shift-add multiply or restoring divide on the shared hi/lo pair.
  // A zero divisor always "fits", which yields all-ones quotient and remainder = a.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = ~div_diff[WIDTH];
    if (op_q[1]) begin
      hi_step = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    iter_res = op_q[0] ? hi_step : lo_step;
  end

  // IDLE/RUN control: accept on start in IDLE, iterate in RUN, publish on the final step
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (sel[3:2] == 2'b10) begin
            state_d = S_RUN;
            cnt_d   = CNT_W'(WIDTH);
            op_d    = sel[1:0];
            b_d     = b;
            hi_d    = '0;
            lo_d    = a;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = iter_res;
          zero_d   = (iter_res == '0);
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears outputs and aborts any iteration in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q == S_RUN);
  assign done   = done_q;

endmodule

// File: tb/tb_alu_iterative.sv
module tb_alu_iterative;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    sel;
  logic [W-1:0]  a, b;
  logic [W-1:0]  result;
  logic          zero, ovf, busy, done;

  logic          start8;
  logic [3:0]    sel8;
  logic [7:0]    a8, b8;
  logic [7:0]    result8;
  logic          zero8, ovf8, busy8, done8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_iterative #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .a(a), .b(b),
    .result(result), .zero(zero), .ovf(ovf), .busy(busy), .done(done)
  );

  alu_iterative #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sel(sel8), .a(a8), .b(b8),
    .result(result8), .zero(zero8), .ovf(ovf8), .busy(busy8), .done(done8)
  );

  typedef struct {
    string       name;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];

  function automatic vec_t mk(string n, logic [3:0] s, logic [31:0] va, logic [31:0] vb,
                              logic [31:0] r, logic z, logic o);
    vec_t v;
    v.name = n; v.sel = s; v.a = va; v.b = vb; v.res = r; v.z = z; v.o = o;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one op, scoreboard its expectation, check result/flags/latency/busy span on done
  task automatic run_op(input vec_t v);
    int   n;
    int   busy_cnt;
    logic iter;
    vec_t e;
    iter = (v.sel[3:2] == 2'b10);
    @(negedge clk);
    start = 1'b1; sel = v.sel; a = v.a; b = v.b;
    sb_q.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; busy_cnt = 0;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    e = sb_q.pop_front();
    chk({e.name, " done seen"}, 64'(done), 64'(1));
    chk({e.name, " result"}, 64'(result), 64'(e.res));
    chk({e.name, " zero"}, 64'(zero), 64'(e.z));
    chk({e.name, " ovf"}, 64'(ovf), 64'(e.o));
    chk({e.name, " latency"}, 64'(n), iter ? 64'(W) : 64'(0));
    chk({e.name, " busy cycles"}, 64'(busy_cnt), iter ? 64'(W) : 64'(0));
    chk({e.name, " busy low at done"}, 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk({e.name, " done single pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int   n;
    int   dcnt;
    vec_t e;

    reset = 1'b1; start = 1'b0; sel = '0; a = '0; b = '0;
    start8 = 1'b0; sel8 = '0; a8 = '0; b8 = '0;

    vecs.push_back(mk("ADD ovf",    4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1));
    vecs.push_back(mk("SUB zero",   4'b0110, 32'd5,         32'd5,         32'h0,         1'b1, 1'b0));
    vecs.push_back(mk("SLT minneg", 4'b0111, 32'h8000_0000, 32'h1,         32'h1,         1'b0, 1'b0));
    vecs.push_back(mk("SLT rev",    4'b0111, 32'h1,         32'h8000_0000, 32'h0,         1'b1, 1'b0));
    vecs.push_back(mk("SUB ovf",    4'b0110, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1));
    vecs.push_back(mk("AND",        4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0));
    vecs.push_back(mk("OR",         4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0));
    vecs.push_back(mk("ANDN",       4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_00F0, 1'b0, 1'b0));
    vecs.push_back(mk("ORN",        4'b0101, 32'h0000_F0F0, 32'h0000_FF00, 32'hFFFF_F0FF, 1'b0, 1'b0));
    vecs.push_back(mk("ADD wrap",   4'b0010, 32'hFFFF_FFFF, 32'h2,         32'h1,         1'b0, 1'b0));
    vecs.push_back(mk("UNDEF 0011", 4'b0011, 32'h1234,      32'h5678,      32'h0,         1'b1, 1'b0));
    vecs.push_back(mk("UNDEF 1100", 4'b1100, 32'h1234,      32'h5678,      32'h0,         1'b1, 1'b0));
    vecs.push_back(mk("MUL",        4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0));
    vecs.push_back(mk("MULHU",      4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0));
    vecs.push_back(mk("MUL small",  4'b1000, 32'd1234,      32'd5678,      32'd7006652,   1'b0, 1'b0));
    vecs.push_back(mk("DIVU",       4'b1010, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0));
    vecs.push_back(mk("REMU",       4'b1011, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0));
    vecs.push_back(mk("REMU exact", 4'b1011, 32'd49,        32'd7,         32'd0,         1'b1, 1'b0));
    vecs.push_back(mk("DIVU by0",   4'b1010, 32'h1234,      32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0));
    vecs.push_back(mk("REMU by0",   4'b1011, 32'h1234,      32'h0,         32'h1234,      1'b0, 1'b0));

    // Outputs held at zero while reset is asserted
    #12;
    chk("reset result", 64'(result), 64'(0));
    chk("reset busy",   64'(busy),   64'(0));
    chk("reset done",   64'(done),   64'(0));
    chk("reset zero",   64'(zero),   64'(0));
    chk("reset ovf",    64'(ovf),    64'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

    // Start pulsed while busy is ignored; the MUL completes untouched
    @(negedge clk);
    start = 1'b1; sel = 4'b1000; a = 32'd3; b = 32'd5;
    sb_q.push_back(mk("MUL busy", 4'b1000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (n == 3) begin
        start = 1'b1; sel = 4'b0010; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (n == 4) begin
        chk("ignored start busy", 64'(busy), 64'(1));
        chk("ignored start result held", 64'(result), 64'h1234);
      end
    end
    start = 1'b0;
    e = sb_q.pop_front();
    chk("busy-start MUL latency", 64'(n), 64'(W));
    chk("busy-start MUL result", 64'(result), 64'(e.res));
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("ignored ADD no done", 64'(dcnt), 64'(0));

    // start held high: ADD staged during RUN is accepted on the done cycle
    @(negedge clk);
    start = 1'b1; sel = 4'b1010; a = 32'd100; b = 32'd7;
    sb_q.push_back(mk("b2b DIVU", 4'b1010, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0));
    @(posedge clk); #1;
    sel = 4'b0010; a = 32'd2; b = 32'd3;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb_q.pop_front();
    chk("b2b DIVU latency", 64'(n), 64'(W));
    chk("b2b DIVU result", 64'(result), 64'(e.res));
    sb_q.push_back(mk("b2b ADD", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    e = sb_q.pop_front();
    chk("b2b ADD done", 64'(done), 64'(1));
    chk("b2b ADD result", 64'(result), 64'(e.res));
    chk("b2b ADD busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk("b2b ADD done single", 64'(done), 64'(0));

    // Asynchronous reset mid-cycle during DIVU aborts without a done pulse
    @(negedge clk);
    start = 1'b1; sel = 4'b1010; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("pre-reset busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    chk("abort result", 64'(result), 64'(0));
    chk("abort busy",   64'(busy),   64'(0));
    chk("abort done",   64'(done),   64'(0));
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int k = 0; k < W + 8; k++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("no done after abort", 64'(dcnt), 64'(0));

    // WIDTH=8 instance
    @(negedge clk);
    start8 = 1'b1; sel8 = 4'b1000; a8 = 8'd15; b8 = 8'd17;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("W8 MUL latency", 64'(n), 64'(8));
    chk("W8 MUL result", 64'(result8), 64'hFF);
    chk("W8 MUL zero", 64'(zero8), 64'(0));
    @(negedge clk);
    start8 = 1'b1; sel8 = 4'b1001;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("W8 MULHU latency", 64'(n), 64'(8));
    chk("W8 MULHU result", 64'(result8), 64'h00);
    chk("W8 MULHU zero", 64'(zero8), 64'(1));
    chk("W8 MULHU ovf", 64'(ovf8), 64'(0));

    chk("scoreboard drained", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
